// File: rtl/atan2_cordic_seq.sv
// -----------------------------------------------------------------------------
// atan2_cordic_seq
// Sequential CORDIC vectoring engine. It accepts a signed (x, y) pair and
// returns the four-quadrant arctangent in fixed-point degrees, together with
// the magnitude scaled by the CORDIC gain K ~= 1.64676 (K is not removed).
// One micro-rotation is done per clock, so the latency is ITER cycles.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : input pair valid
//   in_ready   : engine idle and able to accept (registered)
//   in_x, in_y : signed two's complement inputs, W bits
//   out_valid  : result valid, held until out_ready (registered)
//   out_ready  : downstream accepts the result
//   out_angle  : signed degrees, FRAC fractional bits, range (-180, +180]
//   out_mag    : unsigned magnitude * K, W+1 bits
// -----------------------------------------------------------------------------
module atan2_cordic_seq #(
  parameter int W    = 32,
  parameter int ITER = 16,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9+FRAC:0] out_angle,
  output logic [W:0]      out_mag
);

  // x/y carry two guard bits: one for negating -2^(W-1), one for the
  // growth by K*sqrt(2) during the micro-rotations.
  localparam int XW = W + 2;
  // Angle accumulator keeps four extra fractional bits below the output LSB.
  localparam int ZF = FRAC + 4;
  localparam int ZW = 10 + ZF;
  localparam int AW = 10 + FRAC;
  localparam int IW = 5;
  // The arctangent table is stored with 20 fractional bits and rescaled.
  localparam int SH = 20 - ZF;
  localparam logic [31:0] RND = (32'd1 << SH) >> 1;

  localparam logic signed [ZW-1:0] Z90    = ZW'(32'sd90 * (32'sd1 <<< ZF));
  localparam logic signed [ZW-1:0] Z_HALF = ZW'(32'sd8);
  localparam logic signed [ZW-1:0] A180   = ZW'(32'sd180 * (32'sd1 <<< FRAC));
  localparam logic signed [ZW-1:0] A360   = ZW'(32'sd360 * (32'sd1 <<< FRAC));

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                r_state;
  logic signed [XW-1:0]  r_x;
  logic signed [XW-1:0]  r_y;
  logic signed [ZW-1:0]  r_z;
  logic [IW-1:0]         r_i;
  logic                  r_zero;
  logic                  r_negaxis;

  logic signed [XW-1:0]  w_x_ext;
  logic signed [XW-1:0]  w_y_ext;
  logic signed [XW-1:0]  w_x0;
  logic signed [XW-1:0]  w_y0;
  logic signed [ZW-1:0]  w_z0;
  logic signed [XW-1:0]  w_xs;
  logic signed [XW-1:0]  w_ys;
  logic signed [ZW-1:0]  w_rom;
  logic signed [XW-1:0]  w_x_nx;
  logic signed [XW-1:0]  w_y_nx;
  logic signed [ZW-1:0]  w_z_nx;
  logic signed [ZW-1:0]  w_zr;
  logic signed [ZW-1:0]  w_ar;
  logic signed [ZW-1:0]  w_an;
  logic [AW-1:0]         w_ang_fin;
  logic [W:0]            w_mag_fin;

  // atan(2^-i) in degrees, scaled by 2^20, rounded to the accumulator LSB.
  function automatic logic signed [ZW-1:0] atan_rom(input logic [IW-1:0] idx);
    logic [31:0] t;
    case (idx)
      5'd0:    t = 32'd47185920;
      5'd1:    t = 32'd27855475;
      5'd2:    t = 32'd14718068;
      5'd3:    t = 32'd7471121;
      5'd4:    t = 32'd3750058;
      5'd5:    t = 32'd1876857;
      5'd6:    t = 32'd938658;
      5'd7:    t = 32'd469357;
      5'd8:    t = 32'd234682;
      5'd9:    t = 32'd117342;
      5'd10:   t = 32'd58671;
      5'd11:   t = 32'd29335;
      5'd12:   t = 32'd14668;
      5'd13:   t = 32'd7334;
      5'd14:   t = 32'd3667;
      5'd15:   t = 32'd1833;
      5'd16:   t = 32'd917;
      5'd17:   t = 32'd458;
      5'd18:   t = 32'd229;
      5'd19:   t = 32'd115;
      5'd20:   t = 32'd57;
      5'd21:   t = 32'd29;
      5'd22:   t = 32'd14;
      5'd23:   t = 32'd7;
      default: t = 32'd0;
    endcase
    return ZW'((t + RND) >> SH);
  endfunction

  // Sign-extend first so negating the most negative input cannot overflow.
  assign w_x_ext = $signed({{2{in_x[W-1]}}, in_x});
  assign w_y_ext = $signed({{2{in_y[W-1]}}, in_y});

  // Pre-rotation folds the left half-plane into the right one by +/-90 deg.
  always_comb begin
    w_x0 = w_x_ext;
    w_y0 = w_y_ext;
    w_z0 = '0;
    if (!in_x[W-1]) begin
      w_x0 = w_x_ext;
      w_y0 = w_y_ext;
      w_z0 = '0;
    end else if (!in_y[W-1]) begin
      w_x0 = w_y_ext;
      w_y0 = -w_x_ext;
      w_z0 = Z90;
    end else begin
      w_x0 = -w_y_ext;
      w_y0 = w_x_ext;
      w_z0 = -Z90;
    end
  end

  // One micro-rotation: drive y towards zero, accumulate the rotated angle.
  assign w_xs  = r_x >>> r_i;
  assign w_ys  = r_y >>> r_i;
  assign w_rom = atan_rom(r_i);

  always_comb begin
    if (!r_y[XW-1]) begin
      w_x_nx = r_x + w_ys;
      w_y_nx = r_y - w_xs;
      w_z_nx = r_z + w_rom;
    end else begin
      w_x_nx = r_x - w_ys;
      w_y_nx = r_y + w_xs;
      w_z_nx = r_z - w_rom;
    end
  end

  // Round half-up to the output LSB, then wrap into (-180, +180].
  assign w_zr = w_z_nx + Z_HALF;
  assign w_ar = w_zr >>> 4;

  always_comb begin
    if (w_ar > A180) begin
      w_an = w_ar - A360;
    end else if (w_ar <= -A180) begin
      w_an = w_ar + A360;
    end else begin
      w_an = w_ar;
    end
  end

  // Zero vector and negative real axis are decided at load, not by CORDIC,
  // so the origin reads 0 and the negative axis never lands on -180.
  always_comb begin
    if (r_zero) begin
      w_ang_fin = '0;
      w_mag_fin = '0;
    end else if (r_negaxis) begin
      w_ang_fin = AW'(A180);
      w_mag_fin = (W+1)'(w_x_nx);
    end else begin
      w_ang_fin = AW'(w_an);
      w_mag_fin = (W+1)'(w_x_nx);
    end
  end

  // Control FSM, datapath registers and registered handshake/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      r_zero    <= 1'b0;
      r_negaxis <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_angle <= '0;
      out_mag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x       <= w_x0;
            r_y       <= w_y0;
            r_z       <= w_z0;
            r_i       <= '0;
            r_zero    <= (in_x == '0) && (in_y == '0);
            r_negaxis <= in_x[W-1] && (in_y == '0);
            in_ready  <= 1'b0;
            r_state   <= S_ITER;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        S_ITER: begin
          r_x <= w_x_nx;
          r_y <= w_y_nx;
          r_z <= w_z_nx;
          if (r_i == IW'(ITER - 1)) begin
            out_angle <= w_ang_fin;
            out_mag   <= w_mag_fin;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_i <= r_i + 5'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/atan2_cordic_seq.md
# atan2_cordic_seq

Sequential, parametrised CORDIC vectoring engine computing the four-quadrant arctangent of a signed (x, y) pair in fixed-point degrees, plus the gain-scaled vector magnitude. It succeeds the combinational `atan2` function: widths, iteration count and output precision are parameters, and a valid/ready handshake is added on both sides. It sits between the fixed-point I/Q sample path and the phase-tracking logic.

## Interface
- `W`, 32: input width, signed two's complement; the fraction point is irrelevant because only the ratio matters.
- `ITER`, 16: number of CORDIC micro-rotations, 4..24.
- `FRAC`, 8: fractional bits of the output angle.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input pair valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_x` in W: signed x.
- `in_y` in W: signed y.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: downstream accepts the result.
- `out_angle` out 10+FRAC: signed angle in degrees with FRAC fractional bits; range (-180, +180].
- `out_mag` out W+1: unsigned magnitude multiplied by the CORDIC gain K ≈ 1.646760 (not compensated).

## Operation
- The FSM has three states: IDLE, ITER and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` it loads the pre-rotated vector into x/y registers of W+2 bits, zeroes the iteration counter `i`, and moves to ITER.
- **Pre-rotation**
  - x ≥ 0: (x, y, z) = (x, y, 0).
  - x < 0, y ≥ 0: (y, -x, +90).
  - x < 0, y < 0: (-y, x, -90).
  - Sign-extend before negating so that -2^(W-1) does not overflow.
- **ITER** (one micro-rotation per cycle, d = +1 if y ≥ 0 else -1)
  - x ← x + d·(y >>> i)
  - y ← y − d·(x >>> i)
  - z ← z + d·atan(2^-i)
  - The ROM holds atan(2^-i) in degrees with FRAC+4 fractional bits; the z accumulator is 10+FRAC+4 bits.
  - After `i` = ITER-1, go to DONE.
- **DONE entry** (same edge as the last micro-rotation result)
  - `out_angle` = z rounded half-up to FRAC bits.
  - Normalise: if the result is > +180, subtract 360; if it is ≤ -180, add 360.
  - `out_mag` = x (always ≥ 0).
- **DONE**
  - `out_valid` = 1; `out_angle` and `out_mag` stay stable while `out_ready` = 0.
  - On `out_valid` & `out_ready`, go to IDLE.
- **Special inputs**
  - x = y = 0: `out_angle` = 0, `out_mag` = 0. Detected at load and forced at DONE.
  - Negative real axis (x < 0, y = 0) yields exactly +180, never -180.
- **Accuracy**: |`out_angle` − true atan2| ≤ 6 LSB for ITER=16, FRAC=8, excluding x = y = 0.
- **Reset**
  - All state clears asynchronously to IDLE; any in-flight result is discarded.
  - Reset values: `in_ready` = 1 after reset deasserts; `out_valid` = 0; `out_angle` = 0; `out_mag` = 0.

## Timing
- Acceptance edge T: `in_valid` & `in_ready` sampled high.
- Edges T+1 .. T+ITER perform the micro-rotations.
- `out_valid` rises after edge T+ITER, so latency is ITER cycles from the acceptance edge.
- `in_ready` = 0 from after edge T until the FSM returns to IDLE.
- With `out_ready` held at 1:
  - `out_valid` lasts exactly one cycle.
  - `in_ready` is high in the following cycle.
  - Maximum throughput is one result per ITER+2 cycles.
- `out_ready` high while `out_valid` = 0 has no effect.
- `in_valid` while `in_ready` = 0 is ignored; the upstream block holds its data.
- Inputs are sampled only at the acceptance edge; later changes have no effect.

## Test plan
All scenarios use W=32, ITER=16, FRAC=8, with angle tolerance ±6 LSB and magnitude tolerance ±0.01 %.

1. (x, y) = (4194304, 0) → `out_angle` = 0, `out_mag` ≈ 6907008; `out_valid` rises 16 cycles after the acceptance edge.
2. (0, 4194304) → 23040 (+90°). (-4194304, 0) → exactly 46080 (+180°). (-4194304, -1) → near -46080, never below -46079. (0, -4194304) → -23040.
3. Phase sweep: magnitude 16384·256, phases stepping by halving intervals over (-180°, 180°), 2000 vectors → every angle error ≤ 6 LSB after wrap to ±180; none outside (-180, +180].
4. Corners:
   - (-2^31, -2^31) → -34560 (-135°), with no overflow and `out_mag` ≈ 2^31·1.41421·1.64676.
   - (0, 0) → angle 0, magnitude 0.
5. Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid` → outputs stable, `in_ready` stays 0, a new `in_valid` is ignored; release → result is accepted, and `in_ready` = 1 next cycle.
6. Assert `rst_n` = 0 at iteration 7 → `out_valid` and `out_mag` clear at once, `in_ready` is 1 after release, and the next vector (0, 4194304) produces a correct result with no stale output.
